// File: rtl/fdsync_wrarb.sv
// Write-port arbiter and read-merge-load sequencer for one shared 32-bit fd1e sync register.
// Build option FDSYNC_WRARB_FIXPRI_EN: lowest-index request wins (no round-robin pointer).
//
// state | meaning
// IDLE  | waiting for a request; winner and its data/byte enables latched on the edge
// LOAD  | reg_ld high, reg_d carries the byte-merged word
// ACK   | one-cycle ack to the winner, then back to IDLE
module fdsync_wrarb #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*32-1:0] wdata,
  input  logic [NREQ*4-1:0] wbe,
  output logic [NREQ-1:0]   ack,
  input  logic [31:0]       reg_q,
  output logic [31:0]       reg_d,
  output logic              reg_ld,
  output logic              busy,
  output logic [1:0]        gnt_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx_q;
  logic [31:0] data_q;
  logic [3:0]  be_q;

  logic        win_vld;
  logic [1:0]  win_idx;
  logic [31:0] win_data;
  logic [3:0]  win_be;

`ifdef FDSYNC_WRARB_FIXPRI_EN
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        win_vld = 1'b1;
        win_idx = 2'(j);
      end
    end
  end
`else
  logic [1:0] rr_ptr;

  // Scan offsets from far to near so the candidate closest to rr_ptr+1 is assigned last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req[j] && (j == ((int'(rr_ptr) + k) % NREQ))) begin
          win_vld = 1'b1;
          win_idx = 2'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      rr_ptr <= 2'(NREQ - 1);
    end else if (state == ST_LOAD) begin
      rr_ptr <= idx_q;
    end
  end
`endif

  always_comb begin
    win_data = 32'd0;
    win_be   = 4'd0;
    for (int j = 0; j < NREQ; j++) begin
      if (win_idx == 2'(j)) begin
        win_data = wdata[j*32 +: 32];
        win_be   = wbe[j*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state  <= ST_IDLE;
      idx_q  <= 2'd0;
      data_q <= 32'd0;
      be_q   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && win_vld) begin
        idx_q  <= win_idx;
        data_q <= win_data;
        be_q   <= win_be;
      end
      // Cleared as ACK begins so reg_d passes reg_q straight through outside LOAD.
      if (state == ST_LOAD) begin
        be_q <= 4'd0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    reg_ld    = 1'b0;
    busy      = 1'b0;
    ack       = '0;
    case (state)
      ST_IDLE: begin
        if (win_vld) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        reg_ld    = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_ACK;
      end
      ST_ACK: begin
        for (int j = 0; j < NREQ; j++) begin
          ack[j] = (idx_q == 2'(j));
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    reg_d = reg_q;
    for (int k = 0; k < 4; k++) begin
      if (be_q[k]) reg_d[k*8 +: 8] = data_q[k*8 +: 8];
    end
  end

  assign gnt_idx = idx_q;

endmodule

// File: tb/tb_fdsync_wrarb.sv
// Scoreboard bench for fdsync_wrarb: a transaction-level model predicts each write, a negedge monitor checks it.
module tb_fdsync_wrarb;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              resetl = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*32-1:0] wdata = '0;
  logic [NREQ*4-1:0] wbe = '0;
  logic [NREQ-1:0]   ack;
  logic [31:0]       reg_q = 32'd0;
  logic [31:0]       reg_d;
  logic              reg_ld;
  logic              busy;
  logic [1:0]        gnt_idx;

  always #5 clk = ~clk;

  fdsync_wrarb #(.NREQ(NREQ)) dut (
    .clk(clk), .resetl(resetl), .req(req), .wdata(wdata), .wbe(wbe),
    .ack(ack), .reg_q(reg_q), .reg_d(reg_d), .reg_ld(reg_ld),
    .busy(busy), .gnt_idx(gnt_idx)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [3:0]  be;
    int          ld_cyc;
    int          ack_cyc;
  } txn_t;

  txn_t exp_q[$];
  txn_t ack_q[$];
  int   grant_log[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   m_free_at = 0;
  int   m_last = NREQ - 1;
  logic [NREQ-1:0] ack_seen = '0;
  logic [NREQ-1:0] ack_accum = '0;
  logic [31:0]     last_ld_d = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] d, input logic [3:0] be, input logic [31:0] q);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = be[k] ? d[k*8 +: 8] : q[k*8 +: 8];
    return r;
  endfunction

  // Reference model: one write per 3 cycles; winner chosen at the sampling edge.
  always @(posedge clk) begin
    int w;
    txn_t t;
    cyc++;
    if (resetl && cyc >= m_free_at && req != '0) begin
      w = -1;
`ifdef FDSYNC_WRARB_FIXPRI_EN
      for (int j = 0; j < NREQ; j++) if (w < 0 && req[j]) w = j;
`else
      for (int k = 1; k <= NREQ; k++) if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
`endif
      t.idx = w;
      t.data = wdata[w*32 +: 32];
      t.be = wbe[w*4 +: 4];
      t.ld_cyc = cyc;
      t.ack_cyc = cyc + 1;
      exp_q.push_back(t);
      m_free_at = cyc + 3;
      m_last = w;
    end
  end

  always @(negedge clk) begin
    txn_t t;
    logic exp_ld;
    logic [NREQ-1:0] exp_ack;
    exp_ld = (exp_q.size() > 0) && (exp_q[0].ld_cyc == cyc);
    check("reg_ld", 32'(reg_ld), 32'(exp_ld));
    check("busy", 32'(busy), 32'(exp_ld));
    if (exp_ld) begin
      t = exp_q.pop_front();
      check("reg_d_merge", reg_d, merge(t.data, t.be, reg_q));
      check("gnt_idx_load", 32'(gnt_idx), 32'(t.idx));
      grant_log.push_back(t.idx);
      ack_q.push_back(t);
    end else begin
      check("reg_d_pass", reg_d, reg_q);
    end
    if (reg_ld) last_ld_d = reg_d;
    exp_ack = '0;
    if (ack_q.size() > 0 && ack_q[0].ack_cyc == cyc) begin
      t = ack_q.pop_front();
      exp_ack[t.idx] = 1'b1;
      check("gnt_idx_ack", 32'(gnt_idx), 32'(t.idx));
    end
    check("ack", 32'(ack), 32'(exp_ack));
    ack_seen = ack;
    ack_accum = ack_accum | ack;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      tick();
      req = req & ~ack_seen;
    end
  endtask

  task automatic do_reset();
    resetl = 1'b0;
    exp_q.delete();
    ack_q.delete();
    m_free_at = 0;
    m_last = NREQ - 1;
    #1;
    check("rst_reg_ld", 32'(reg_ld), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt_idx", 32'(gnt_idx), 32'd0);
    req = '0;
    repeat (2) tick();
    resetl = 1'b1;
  endtask

  task automatic wait_ld(input string nm);
    int n;
    n = 0;
    while (!reg_ld && n < 12) begin
      tick();
      n++;
    end
    if (!reg_ld) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: reg_ld never rose within 12 cycles", nm);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [3:0] be);
    wdata[i*32 +: 32] = d;
    wbe[i*4 +: 4] = be;
    req[i] = 1'b1;
  endtask

  initial begin
    int exp_order[5];
    int n;
    do_reset();

    // Full-word write from requester 1.
    reg_q = 32'd0;
    set_req(1, 32'h12345678, 4'b1111);
    grant_log.delete();
    run(8);
    check("t1_data", last_ld_d, 32'h12345678);
    check("t1_gnt_idx", 32'(gnt_idx), 32'd1);
    check("t1_grants", 32'(grant_log.size()), 32'd1);

    // Byte-masked merge.
    reg_q = 32'hAABBCCDD;
    set_req(0, 32'h11223344, 4'b0101);
    run(8);
    check("t2_data", last_ld_d, 32'hAA22CC44);

    // All requesters held high from reset.
    do_reset();
`ifdef FDSYNC_WRARB_FIXPRI_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, 4'(($urandom)));
    grant_log.delete();
    n = 0;
    while (grant_log.size() < 5 && n < 40) begin
      tick();
      n++;
    end
    req = '0;
    run(6);
    for (int i = 0; i < 5; i++)
      check($sformatf("t3_order%0d", i), 32'(grant_log.size() > i ? grant_log[i] : -1), 32'(exp_order[i]));

    // Zero byte enables still run a full cycle.
    reg_q = 32'h5A5AC3C3;
    ack_accum = '0;
    set_req(2, 32'hFFFFFFFF, 4'b0000);
    run(8);
    check("t4_data", last_ld_d, 32'h5A5AC3C3);
    check("t4_ack", 32'(ack_accum), 32'b0100);

    // Drop during LOAD completes; drop before sampling does nothing.
    ack_accum = '0;
    set_req(3, 32'hCAFEF00D, 4'b1111);
    wait_ld("t5_wait");
    req[3] = 1'b0;
    set_req(1, 32'hDEADBEEF, 4'b1111);
    tick();
    req[1] = 1'b0;
    run(8);
    check("t5_ack", 32'(ack_accum), 32'b1000);

    // Reset during LOAD aborts, then 0 beats 3.
    set_req(0, 32'h01020304, 4'b1111);
    wait_ld("t6_wait");
    ack_accum = '0;
    do_reset();
    check("t6_no_ack", 32'(ack_accum), 32'd0);
    grant_log.delete();
    set_req(0, 32'h0BADF00D, 4'b1111);
    set_req(3, 32'h33333333, 4'b1111);
    run(3);
    req = '0;
    run(6);
    check("t6_winner", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

    // Randomized traffic, including withdrawals and a changing reg_q.
    for (int c = 0; c < 2000; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (ack_seen[i]) begin
          req[i] = 1'b0;
          if ($urandom_range(3) == 0) set_req(i, $urandom, 4'($urandom_range(15)));
        end else if (!req[i]) begin
          if ($urandom_range(2) == 0) set_req(i, $urandom, 4'($urandom_range(15)));
        end else if ($urandom_range(19) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(1) == 0) reg_q = $urandom;
    end
    req = '0;
    run(8);
    check("drain_ld", 32'(exp_q.size()), 32'd0);
    check("drain_ack", 32'(ack_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
